rca_config_sequencer: RTL
=========================

# rca_config_sequencer

Queues RCA configuration instructions (funct7 2–8 on the custom-1 opcode) from the issue stage and serialises them onto the reconfigurable accelerator's configuration write bus, one write per cycle at most. It tracks outstanding writes per RCA unit and gates issue of RCA_USE_FB/RCA_USE_NFB instructions, so a unit is never used while partially configured. Sits between decode/issue and the RCA grid configuration memories.

## Interface
- NUM_RCAS, 4: number of RCA units; ID width RW = $clog2(NUM_RCAS)
- FIFO_DEPTH, 4: configuration command queue entries (power of 2, ≥2)
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  config instruction presented
- issue_ready  out  1  command accepted this cycle when high with issue_valid
- issue_funct7  in  7  instruction[31:25]
- issue_rca_sel  in  RW  target RCA unit
- issue_rs1  in  32  config address/selector operand
- issue_rs2  in  32  config data operand
- use_valid  in  1  USE_FB/USE_NFB wants to issue
- use_rca_sel  in  RW  unit requested
- use_grant  out  1  use instruction may issue
- cfg_valid  out  1  write presented on config bus
- cfg_type  out  3  0=CPU_REG,1=GRID_MUX,2=IO_MUX,3=RESULT_MUX,4=IO_INP_MAP,5=INP_CONSTANT,6=LS_MASK
- cfg_rca_sel  out  RW  unit written
- cfg_addr  out  32  issue_rs1 of head command
- cfg_data  out  32  issue_rs2 of head command
- cfg_ack  in  1  config bus consumed current write
- rca_configured  out  NUM_RCAS  per-unit "configured and idle" flag
- illegal_cfg  out  1  one-cycle pulse: dropped command

## Operation
- FIFO of {type, rca_sel, rs1, rs2}; registered head/tail pointers plus count (width $clog2(FIFO_DEPTH+1)).
- issue_ready = !full; depends only on registered state, never on issue_valid or cfg_ack (no pass-through when full, even with simultaneous pop).
- Accept = issue_valid & issue_ready. funct7 in 2..8: enqueue with cfg_type = funct7−2. Other funct7 (incl. 0/1 USE ops): accepted, not enqueued, illegal_cfg = 1 next cycle.
- cfg_valid = !empty; cfg_* driven from FIFO head; held stable until cfg_ack. cfg_ack with cfg_valid low ignored.
- Pop on cfg_valid & cfg_ack; next entry presented next cycle (back-to-back writes allowed).
- pending[u] counter per unit (width $clog2(FIFO_DEPTH+1)): +1 on enqueue to u, −1 on pop from u; both same cycle to same u → unchanged.
- rca_configured[u]: cleared on enqueue to u; set on cycle after pop that brings pending[u] to 0 with no enqueue to u that cycle. Enqueue clear wins over simultaneous set.
- use_grant = use_valid & rca_configured[use_rca_sel] & (pending[use_rca_sel]==0). Combinational.
- Write ordering: strict FIFO, across all units.

## Timing
- Reset values: issue_ready=1, cfg_valid=0, cfg_* = 0, use_grant=0, rca_configured=0, illegal_cfg=0; FIFO empty, all pending=0.
- rst sampled at edge e: all state at reset values after e; in-flight write abandoned (cfg_valid low from cycle after e regardless of cfg_ack).
- Latency: accept at edge t into empty FIFO → cfg_valid high in cycle after t.
- Throughput: 1 write/cycle when cfg_ack held high.
- Full: count==FIFO_DEPTH → issue_ready=0 that cycle; returns high cycle after a pop.
- Pointers wrap modulo FIFO_DEPTH.
- illegal_cfg: registered, one cycle, after accept edge.
- rca_configured[u] rises cycle after final ack; use_grant for u possible in same cycle.

## Test plan
- Reset then single GRID_MUX write (funct7=3, rca_sel=1, rs1=0x10, rs2=0xAB) → next cycle cfg_valid=1, type=1, addr=0x10, data=0xAB; ack → rca_configured=4'b0010; use_grant for unit 1 =1, unit 0 =0.
- Enqueue 5 commands, cfg_ack=0 → 4 accepted, issue_ready=0 at 5th; one ack → ready=1 next cycle, FIFO order preserved on bus.
- cfg_ack held 1, 4 commands → 4 consecutive cfg_valid cycles, entries in issue order; pending reaches 0.
- Enqueue to unit 2 same cycle as final ack of unit 2 → pending[2] stays 1, rca_configured[2]=0, use_grant for unit 2 denied.
- funct7=0 and funct7=9 accepted → illegal_cfg pulses 1 cycle each, cfg_valid stays 0, pending unchanged.
- rst asserted with 3 queued and cfg_valid=1 → next cycle cfg_valid=0, issue_ready=1, rca_configured=0, use_grant=0.

Source files
------------

// File: rtl/rca_config_sequencer.sv
// rca_config_sequencer: queues RCA config instructions onto the config write bus and gates RCA use until units are fully configured
module rca_config_sequencer #(
    parameter int NUM_RCAS   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int RW         = $clog2(NUM_RCAS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [6:0]          issue_funct7,
    input  logic [RW-1:0]       issue_rca_sel,
    input  logic [31:0]         issue_rs1,
    input  logic [31:0]         issue_rs2,
    input  logic                use_valid,
    input  logic [RW-1:0]       use_rca_sel,
    output logic                use_grant,
    output logic                cfg_valid,
    output logic [2:0]          cfg_type,
    output logic [RW-1:0]       cfg_rca_sel,
    output logic [31:0]         cfg_addr,
    output logic [31:0]         cfg_data,
    input  logic                cfg_ack,
    output logic [NUM_RCAS-1:0] rca_configured,
    output logic                illegal_cfg
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [2:0]    mem_type [FIFO_DEPTH];
    logic [RW-1:0] mem_sel  [FIFO_DEPTH];
    logic [31:0]   mem_addr [FIFO_DEPTH];
    logic [31:0]   mem_data [FIFO_DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic [CW-1:0] pending [NUM_RCAS];
    logic          accept, legal, enq, pop;
    logic [NUM_RCAS-1:0] inc, dec;

    assign issue_ready = count != CW'(FIFO_DEPTH);
    assign cfg_valid   = count != '0;
    assign cfg_type    = cfg_valid ? mem_type[head] : '0;
    assign cfg_rca_sel = cfg_valid ? mem_sel[head]  : '0;
    assign cfg_addr    = cfg_valid ? mem_addr[head] : '0;
    assign cfg_data    = cfg_valid ? mem_data[head] : '0;
    assign accept      = issue_valid & issue_ready;
    assign legal       = issue_funct7 >= 7'd2 && issue_funct7 <= 7'd8;
    assign enq         = accept & legal;
    assign pop         = cfg_valid & cfg_ack;
    assign use_grant   = use_valid & rca_configured[use_rca_sel] & (pending[use_rca_sel] == '0);

    always_comb begin
        inc = '0;
        dec = '0;
        for (int u = 0; u < NUM_RCAS; u++) begin
            inc[u] = enq && issue_rca_sel == RW'(u);
            dec[u] = pop && cfg_rca_sel == RW'(u);
        end
    end

    // Payload storage needs no reset: cfg_* are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_type[tail] <= issue_funct7[2:0] - 3'd2;
            mem_sel[tail]  <= issue_rca_sel;
            mem_addr[tail] <= issue_rs1;
            mem_data[tail] <= issue_rs2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            illegal_cfg    <= 1'b0;
            rca_configured <= '0;
            for (int u = 0; u < NUM_RCAS; u++) pending[u] <= '0;
        end else begin
            head        <= pop ? head + PW'(1) : head;
            tail        <= enq ? tail + PW'(1) : tail;
            count       <= count + CW'(enq) - CW'(pop);
            illegal_cfg <= accept & ~legal;
            // A new enqueue to a unit overrides the set from its final pop.
            for (int u = 0; u < NUM_RCAS; u++) begin
                pending[u]        <= pending[u] + CW'(inc[u]) - CW'(dec[u]);
                rca_configured[u] <= inc[u] ? 1'b0 :
                                     (dec[u] && pending[u] == CW'(1)) ? 1'b1 : rca_configured[u];
            end
        end
    end
endmodule
